// File: rtl/exu_wb_collector.sv
// Execution-side writeback collector: tracks ALU1/ALU2/MMU occupancy for dual issue
// and drains finished results onto two register-file write ports, oldest PC first.
module exu_wb_collector #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned RAW  = 5,
   parameter int unsigned CNTW = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        iss1_sel,
   input  logic [XLEN-1:0]   iss1_pc,
   input  logic [RAW-1:0]    iss1_rd,
   input  logic              iss1_wen,
   input  logic [2:0]        iss2_sel,
   input  logic [XLEN-1:0]   iss2_pc,
   input  logic [RAW-1:0]    iss2_rd,
   input  logic              iss2_wen,
   input  logic [2:0]        done_vld,
   input  logic [3*XLEN-1:0] done_data,
   input  logic              flush,
   output logic              aluo_busy,
   output logic              alut_busy,
   output logic              mmu_busy,
   output logic [RAW-1:0]    aluo_addr,
   output logic [RAW-1:0]    alut_addr,
   output logic [RAW-1:0]    mmu_addr,
   output logic              aluo_ena,
   output logic              alut_ena,
   output logic              mmu_ena,
   output logic              wb0_en,
   output logic              wb1_en,
   output logic [RAW-1:0]    wb0_addr,
   output logic [RAW-1:0]    wb1_addr,
   output logic [XLEN-1:0]   wb0_data,
   output logic [XLEN-1:0]   wb1_data,
   output logic [CNTW-1:0]   wb_count,
   output logic              err_issue_busy
);
   localparam int unsigned NU = 3;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WBWAIT = 2'd2} state_t;

   state_t          st_q   [NU];
   state_t          st_d   [NU];
   logic [XLEN-1:0] pc_q   [NU];
   logic [XLEN-1:0] pc_d   [NU];
   logic [XLEN-1:0] data_q [NU];
   logic [XLEN-1:0] data_d [NU];
   logic [RAW-1:0]  rd_q   [NU];
   logic [RAW-1:0]  rd_d   [NU];
   logic            wen_q  [NU];
   logic            wen_d  [NU];
   logic [1:0]      rank   [NU];
   logic [NU-1:0]   waiting;
   logic [NU-1:0]   freed;
   logic [1:0]      sel0, sel1;
   logic            has0, has1;
   logic            err_d;

   // Age ordering of waiting entries: rank = number of waiting entries older than this one.
   always_comb begin
      waiting = '0;
      freed   = '0;
      has0    = 1'b0;
      has1    = 1'b0;
      sel0    = 2'd0;
      sel1    = 2'd0;
      for (int i = 0; i < NU; i++) waiting[i] = (st_q[i] == WBWAIT);
      for (int i = 0; i < NU; i++) begin
         rank[i] = 2'd0;
         for (int j = 0; j < NU; j++) begin
            if (j != i && waiting[j] &&
                (pc_q[j] < pc_q[i] || (pc_q[j] == pc_q[i] && j < i)))
               rank[i] = rank[i] + 2'd1;
         end
      end
      for (int i = 0; i < NU; i++) begin
         if (waiting[i] && rank[i] == 2'd0) begin
            has0 = 1'b1;
            sel0 = 2'(i);
         end
         if (waiting[i] && rank[i] == 2'd1) begin
            has1 = 1'b1;
            sel1 = 2'(i);
         end
      end
      // Second port yields when both winners target the same register.
      wb0_en   = has0 && !rst;
      wb1_en   = has1 && !rst && (rd_q[sel1] != rd_q[sel0]);
      wb0_addr = wb0_en ? rd_q[sel0]   : '0;
      wb0_data = wb0_en ? data_q[sel0] : '0;
      wb1_addr = wb1_en ? rd_q[sel1]   : '0;
      wb1_data = wb1_en ? data_q[sel1] : '0;
      for (int i = 0; i < NU; i++)
         freed[i] = (wb0_en && sel0 == 2'(i)) || (wb1_en && sel1 == 2'(i));
   end

   // Per-unit next state: completion, flush, drain, then grant acceptance.
   always_comb begin
      err_d = err_issue_busy;
      for (int u = 0; u < NU; u++) begin
         st_d[u]   = st_q[u];
         pc_d[u]   = pc_q[u];
         rd_d[u]   = rd_q[u];
         wen_d[u]  = wen_q[u];
         data_d[u] = data_q[u];
         case (st_q[u])
            EXEC: begin
               if (flush) begin
                  st_d[u] = IDLE;
               end else if (done_vld[u]) begin
                  if (wen_q[u] && rd_q[u] != '0) begin
                     st_d[u]   = WBWAIT;
                     data_d[u] = done_data[u*XLEN +: XLEN];
                  end else begin
                     st_d[u] = IDLE;
                  end
               end
            end
            WBWAIT: if (freed[u]) st_d[u] = IDLE;
            default: ;
         endcase
         if (iss1_sel[u] || iss2_sel[u]) begin
            if (st_q[u] == IDLE || (st_q[u] == EXEC && flush) || freed[u]) begin
               st_d[u]  = EXEC;
               pc_d[u]  = iss1_sel[u] ? iss1_pc  : iss2_pc;
               rd_d[u]  = iss1_sel[u] ? iss1_rd  : iss2_rd;
               wen_d[u] = iss1_sel[u] ? iss1_wen : iss2_wen;
            end else begin
               err_d = 1'b1;
            end
            if (iss1_sel[u] && iss2_sel[u]) err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int u = 0; u < NU; u++) begin
            st_q[u]   <= IDLE;
            pc_q[u]   <= '0;
            rd_q[u]   <= '0;
            wen_q[u]  <= 1'b0;
            data_q[u] <= '0;
         end
         err_issue_busy <= 1'b0;
         wb_count       <= '0;
         aluo_busy <= 1'b0; alut_busy <= 1'b0; mmu_busy <= 1'b0;
         aluo_addr <= '0;   alut_addr <= '0;   mmu_addr <= '0;
         aluo_ena  <= 1'b0; alut_ena  <= 1'b0; mmu_ena  <= 1'b0;
      end else begin
         for (int u = 0; u < NU; u++) begin
            st_q[u]   <= st_d[u];
            pc_q[u]   <= pc_d[u];
            rd_q[u]   <= rd_d[u];
            wen_q[u]  <= wen_d[u];
            data_q[u] <= data_d[u];
         end
         err_issue_busy <= err_d;
         wb_count       <= wb_count + CNTW'(wb0_en) + CNTW'(wb1_en);
         aluo_busy <= (st_d[0] != IDLE);
         alut_busy <= (st_d[1] != IDLE);
         mmu_busy  <= (st_d[2] != IDLE);
         aluo_addr <= (st_d[0] != IDLE) ? rd_d[0] : '0;
         alut_addr <= (st_d[1] != IDLE) ? rd_d[1] : '0;
         mmu_addr  <= (st_d[2] != IDLE) ? rd_d[2] : '0;
         aluo_ena  <= (st_d[0] != IDLE) && wen_d[0];
         alut_ena  <= (st_d[1] != IDLE) && wen_d[1];
         mmu_ena   <= (st_d[2] != IDLE) && wen_d[2];
      end
   end
endmodule

// File: tb/tb_exu_wb_collector.sv
// Bench for exu_wb_collector: directed scenarios plus random traffic checked against
// an entry-list model of outstanding unit work.
module tb_exu_wb_collector;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    iss1_sel, iss2_sel, done_vld;
   logic [63:0]   iss1_pc, iss2_pc;
   logic [4:0]    iss1_rd, iss2_rd;
   logic          iss1_wen, iss2_wen, flush;
   logic [191:0]  done_data;
   logic          aluo_busy, alut_busy, mmu_busy, aluo_ena, alut_ena, mmu_ena;
   logic [4:0]    aluo_addr, alut_addr, mmu_addr, wb0_addr, wb1_addr;
   logic          wb0_en, wb1_en, err_issue_busy;
   logic [63:0]   wb0_data, wb1_data, wb_count;

   exu_wb_collector dut (
      .clk(clk), .rst(rst),
      .iss1_sel(iss1_sel), .iss1_pc(iss1_pc), .iss1_rd(iss1_rd), .iss1_wen(iss1_wen),
      .iss2_sel(iss2_sel), .iss2_pc(iss2_pc), .iss2_rd(iss2_rd), .iss2_wen(iss2_wen),
      .done_vld(done_vld), .done_data(done_data), .flush(flush),
      .aluo_busy(aluo_busy), .alut_busy(alut_busy), .mmu_busy(mmu_busy),
      .aluo_addr(aluo_addr), .alut_addr(alut_addr), .mmu_addr(mmu_addr),
      .aluo_ena(aluo_ena), .alut_ena(alut_ena), .mmu_ena(mmu_ena),
      .wb0_en(wb0_en), .wb1_en(wb1_en), .wb0_addr(wb0_addr), .wb1_addr(wb1_addr),
      .wb0_data(wb0_data), .wb1_data(wb1_data), .wb_count(wb_count),
      .err_issue_busy(err_issue_busy)
   );

   always #5 clk = ~clk;

   logic [2:0] d_busy, d_ena;
   logic [4:0] d_addr [3];
   assign d_busy = {mmu_busy, alut_busy, aluo_busy};
   assign d_ena  = {mmu_ena, alut_ena, aluo_ena};
   assign d_addr[0] = aluo_addr;
   assign d_addr[1] = alut_addr;
   assign d_addr[2] = mmu_addr;

   int n_checks = 0;
   int n_err    = 0;

   // Model: units either run (m_exec) or own one finished entry waiting for a port.
   typedef struct {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic [63:0] data;
      int          unit;
   } ent_t;

   ent_t        pend[$];
   bit          m_exec [3] = '{0, 0, 0};
   logic [63:0] m_pc   [3];
   logic [4:0]  m_rd   [3] = '{0, 0, 0};
   bit          m_wen  [3] = '{0, 0, 0};
   logic [63:0] m_count = '0;
   bit          m_err = 0;
   int          ex_i0, ex_i1;
   bit          e_wb0_en, e_wb1_en;
   logic [4:0]  e_wb0_addr, e_wb1_addr;
   logic [63:0] e_wb0_data, e_wb1_data;

   function automatic bit older(ent_t a, ent_t b);
      return (a.pc < b.pc) || (a.pc == b.pc && a.unit < b.unit);
   endfunction

   function automatic bit m_busy(int u);
      bit b = m_exec[u];
      foreach (pend[k]) if (pend[k].unit == u) b = 1;
      return b;
   endfunction

   task automatic model_comb();
      ex_i0 = -1; ex_i1 = -1;
      foreach (pend[k]) begin
         if (ex_i0 < 0 || older(pend[k], pend[ex_i0])) begin
            ex_i1 = ex_i0; ex_i0 = k;
         end else if (ex_i1 < 0 || older(pend[k], pend[ex_i1])) begin
            ex_i1 = k;
         end
      end
      e_wb0_en = !rst && ex_i0 >= 0;
      e_wb1_en = e_wb0_en && ex_i1 >= 0 && pend[ex_i1].rd != pend[ex_i0].rd;
      e_wb0_addr = e_wb0_en ? pend[ex_i0].rd : 5'd0;
      e_wb0_data = e_wb0_en ? pend[ex_i0].data : 64'd0;
      e_wb1_addr = e_wb1_en ? pend[ex_i1].rd : 5'd0;
      e_wb1_data = e_wb1_en ? pend[ex_i1].data : 64'd0;
   endtask

   task automatic model_seq();
      bit was_busy [3];
      bit freed [3];
      if (rst) begin
         pend.delete();
         for (int u = 0; u < 3; u++) begin m_exec[u] = 0; m_rd[u] = 0; m_wen[u] = 0; end
         m_count = 0; m_err = 0;
         return;
      end
      for (int u = 0; u < 3; u++) begin was_busy[u] = m_busy(u); freed[u] = 0; end
      if (e_wb0_en) freed[pend[ex_i0].unit] = 1;
      if (e_wb1_en) freed[pend[ex_i1].unit] = 1;
      m_count = m_count + 64'(e_wb0_en) + 64'(e_wb1_en);
      if (e_wb1_en && ex_i1 > ex_i0) begin pend.delete(ex_i1); pend.delete(ex_i0); end
      else if (e_wb1_en) begin pend.delete(ex_i0); pend.delete(ex_i1); end
      else if (e_wb0_en) pend.delete(ex_i0);
      for (int u = 0; u < 3; u++) begin
         if (m_exec[u] && (flush || done_vld[u])) begin
            if (!flush && m_wen[u] && m_rd[u] != 0)
               pend.push_back('{pc: m_pc[u], rd: m_rd[u], data: done_data[u*64 +: 64], unit: u});
            m_exec[u] = 0;
         end
      end
      for (int u = 0; u < 3; u++) begin
         if (iss1_sel[u] || iss2_sel[u]) begin
            if (!was_busy[u] || (was_busy[u] && !m_busy(u) && !freed[u] && flush) || freed[u]) begin
               m_exec[u] = 1;
               m_pc[u]  = iss1_sel[u] ? iss1_pc  : iss2_pc;
               m_rd[u]  = iss1_sel[u] ? iss1_rd  : iss2_rd;
               m_wen[u] = iss1_sel[u] ? iss1_wen : iss2_wen;
            end else m_err = 1;
            if (iss1_sel[u] && iss2_sel[u]) m_err = 1;
         end
      end
   endtask

   task automatic idle_in();
      iss1_sel = 0; iss1_pc = 0; iss1_rd = 0; iss1_wen = 0;
      iss2_sel = 0; iss2_pc = 0; iss2_rd = 0; iss2_wen = 0;
      done_vld = 0; done_data = '0; flush = 0;
   endtask

   task automatic settle();
      #1 model_comb();
   endtask

   task automatic clock();
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic test_reset();
      rst = 1; idle_in(); settle(); clock(); rst = 0;
      n_checks++;
      if ({d_busy, d_ena, aluo_addr, alut_addr, mmu_addr, wb0_en, wb1_en, err_issue_busy} !== '0 ||
          wb_count !== 64'd0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b ena=%b wb_en=%b%b err=%b count=%0d, want all 0",
                  d_busy, d_ena, wb0_en, wb1_en, err_issue_busy, wb_count);
      end
   endtask

   task automatic test_single();
      idle_in(); iss1_sel = 3'b001; iss1_pc = 64'h100; iss1_rd = 5'd5; iss1_wen = 1;
      settle(); clock();
      n_checks++;
      if (aluo_busy !== 1'b1 || aluo_addr !== 5'd5 || aluo_ena !== 1'b1) begin
         n_err++; $display("FAIL single_exec: busy=%b addr=%0d ena=%b, want 1 5 1", aluo_busy, aluo_addr, aluo_ena);
      end
      idle_in(); done_vld = 3'b001; done_data[63:0] = 64'hAB;
      settle();
      n_checks++;
      if (wb0_en !== 1'b0) begin n_err++; $display("FAIL single_early: wb0_en=%b, want 0", wb0_en); end
      clock();
      n_checks++;
      if (aluo_busy !== 1'b1) begin n_err++; $display("FAIL single_wait_busy: busy=%b, want 1", aluo_busy); end
      idle_in(); settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_addr !== 5'd5 || wb0_data !== 64'hAB || wb1_en !== 1'b0) begin
         n_err++; $display("FAIL single_write: en=%b addr=%0d data=%h wb1=%b, want 1 5 ab 0", wb0_en, wb0_addr, wb0_data, wb1_en);
      end
      clock();
      n_checks++;
      if (aluo_busy !== 1'b0 || wb_count !== 64'd1) begin
         n_err++; $display("FAIL single_retire: busy=%b count=%0d, want 0 1", aluo_busy, wb_count);
      end
   endtask

   task automatic test_order();
      idle_in();
      iss1_sel = 3'b001; iss1_pc = 64'h200; iss1_rd = 5'd3; iss1_wen = 1;
      iss2_sel = 3'b010; iss2_pc = 64'h1F0; iss2_rd = 5'd4; iss2_wen = 1;
      settle(); clock();
      idle_in(); iss1_sel = 3'b100; iss1_pc = 64'h210; iss1_rd = 5'd6; iss1_wen = 1;
      settle(); clock();
      idle_in(); done_vld = 3'b111; done_data = {64'h33, 64'h22, 64'h11};
      settle(); clock();
      idle_in(); settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_addr !== 5'd4 || wb0_data !== 64'h22 ||
          wb1_en !== 1'b1 || wb1_addr !== 5'd3 || wb1_data !== 64'h11) begin
         n_err++; $display("FAIL order_first: wb0=%b/%0d/%h wb1=%b/%0d/%h, want 1/4/22 1/3/11",
                           wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data);
      end
      clock(); settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_addr !== 5'd6 || wb0_data !== 64'h33 || wb1_en !== 1'b0) begin
         n_err++; $display("FAIL order_second: wb0=%b/%0d/%h wb1=%b, want 1/6/33 0", wb0_en, wb0_addr, wb0_data, wb1_en);
      end
      clock();
      n_checks++;
      if (wb_count !== 64'd4) begin n_err++; $display("FAIL order_count: count=%0d, want 4", wb_count); end
   endtask

   task automatic test_same_rd();
      idle_in();
      iss1_sel = 3'b001; iss1_pc = 64'h10; iss1_rd = 5'd7; iss1_wen = 1;
      iss2_sel = 3'b010; iss2_pc = 64'h14; iss2_rd = 5'd7; iss2_wen = 1;
      settle(); clock();
      idle_in(); done_vld = 3'b011; done_data[127:0] = {64'hA2, 64'hA1};
      settle(); clock();
      idle_in(); settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_addr !== 5'd7 || wb0_data !== 64'hA1 || wb1_en !== 1'b0) begin
         n_err++; $display("FAIL samerd_first: wb0=%b/%0d/%h wb1=%b, want 1/7/a1 0", wb0_en, wb0_addr, wb0_data, wb1_en);
      end
      clock(); settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_data !== 64'hA2 || wb1_en !== 1'b0) begin
         n_err++; $display("FAIL samerd_second: wb0=%b/%h wb1=%b, want 1/a2 0", wb0_en, wb0_data, wb1_en);
      end
      clock();
      n_checks++;
      if (wb_count !== 64'd6) begin n_err++; $display("FAIL samerd_count: count=%0d, want 6", wb_count); end
   endtask

   task automatic test_rd_zero();
      idle_in(); iss1_sel = 3'b100; iss1_pc = 64'h300; iss1_rd = 5'd0; iss1_wen = 1;
      settle(); clock();
      idle_in(); done_vld = 3'b100; done_data[191:128] = 64'h77;
      settle(); clock();
      n_checks++;
      if (mmu_busy !== 1'b0) begin n_err++; $display("FAIL rd0_busy: mmu_busy=%b, want 0", mmu_busy); end
      idle_in(); settle();
      n_checks++;
      if (wb0_en !== 1'b0 || wb1_en !== 1'b0) begin
         n_err++; $display("FAIL rd0_nowrite: wb_en=%b%b, want 00", wb0_en, wb1_en);
      end
      clock();
      n_checks++;
      if (wb_count !== 64'd6) begin n_err++; $display("FAIL rd0_count: count=%0d, want 6", wb_count); end
   endtask

   task automatic test_flush();
      idle_in();
      iss1_sel = 3'b001; iss1_pc = 64'h50; iss1_rd = 5'd9;  iss1_wen = 1;
      iss2_sel = 3'b010; iss2_pc = 64'h40; iss2_rd = 5'd10; iss2_wen = 1;
      settle(); clock();
      idle_in(); done_vld = 3'b001; done_data[63:0] = 64'hE1;
      settle(); clock();
      idle_in(); flush = 1; done_vld = 3'b010; done_data[127:64] = 64'hE2;
      settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_addr !== 5'd9 || wb0_data !== 64'hE1 || wb1_en !== 1'b0) begin
         n_err++; $display("FAIL flush_drain: wb0=%b/%0d/%h wb1=%b, want 1/9/e1 0", wb0_en, wb0_addr, wb0_data, wb1_en);
      end
      clock();
      n_checks++;
      if (alut_busy !== 1'b0 || aluo_busy !== 1'b0 || wb_count !== 64'd7) begin
         n_err++; $display("FAIL flush_kill: alut=%b aluo=%b count=%0d, want 0 0 7", alut_busy, aluo_busy, wb_count);
      end
      idle_in(); settle();
      n_checks++;
      if (wb0_en !== 1'b0) begin n_err++; $display("FAIL flush_nowrite: wb0_en=%b, want 0", wb0_en); end
      clock();
   endtask

   task automatic test_back_to_back();
      idle_in(); iss1_sel = 3'b001; iss1_pc = 64'h80; iss1_rd = 5'd14; iss1_wen = 1;
      settle(); clock();
      idle_in(); done_vld = 3'b001; done_data[63:0] = 64'hC1;
      settle(); clock();
      idle_in(); iss1_sel = 3'b001; iss1_pc = 64'h90; iss1_rd = 5'd15; iss1_wen = 1;
      settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_addr !== 5'd14) begin
         n_err++; $display("FAIL b2b_write: wb0=%b/%0d, want 1/14", wb0_en, wb0_addr);
      end
      clock();
      n_checks++;
      if (aluo_busy !== 1'b1 || aluo_addr !== 5'd15 || err_issue_busy !== 1'b0 || wb_count !== 64'd8) begin
         n_err++; $display("FAIL b2b_regrant: busy=%b addr=%0d err=%b count=%0d, want 1 15 0 8",
                           aluo_busy, aluo_addr, err_issue_busy, wb_count);
      end
      idle_in(); done_vld = 3'b001; done_data[63:0] = 64'hC2;
      settle(); clock();
      idle_in(); settle();
      n_checks++;
      if (wb0_en !== 1'b1 || wb0_addr !== 5'd15 || wb0_data !== 64'hC2) begin
         n_err++; $display("FAIL b2b_second: wb0=%b/%0d/%h, want 1/15/c2", wb0_en, wb0_addr, wb0_data);
      end
      clock();
   endtask

   task automatic test_busy_and_reset();
      idle_in(); iss1_sel = 3'b001; iss1_pc = 64'h60; iss1_rd = 5'd12; iss1_wen = 1;
      settle(); clock();
      idle_in(); iss1_sel = 3'b001; iss1_pc = 64'h70; iss1_rd = 5'd13; iss1_wen = 1;
      settle(); clock();
      n_checks++;
      if (err_issue_busy !== 1'b1 || aluo_addr !== 5'd12) begin
         n_err++; $display("FAIL busy_grant: err=%b addr=%0d, want 1 12", err_issue_busy, aluo_addr);
      end
      idle_in(); done_vld = 3'b001; done_data[63:0] = 64'hD1;
      settle(); clock();
      n_checks++;
      if (err_issue_busy !== 1'b1 || aluo_busy !== 1'b1) begin
         n_err++; $display("FAIL busy_sticky: err=%b busy=%b, want 1 1", err_issue_busy, aluo_busy);
      end
      idle_in(); rst = 1; settle();
      n_checks++;
      if (wb0_en !== 1'b0 || wb1_en !== 1'b0) begin
         n_err++; $display("FAIL rst_nowrite: wb_en=%b%b, want 00", wb0_en, wb1_en);
      end
      clock(); rst = 0;
      n_checks++;
      if (d_busy !== 3'b0 || err_issue_busy !== 1'b0 || wb_count !== 64'd0 || aluo_addr !== 5'd0) begin
         n_err++; $display("FAIL rst_clear: busy=%b err=%b count=%0d addr=%0d, want 0 0 0 0",
                           d_busy, err_issue_busy, wb_count, aluo_addr);
      end
   endtask

   function automatic logic [2:0] pick_sel();
      int r = $urandom_range(0, 5);
      return (r < 3) ? 3'(1 << r) : 3'b000;
   endfunction

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         iss1_sel = pick_sel(); iss1_pc = 64'($urandom_range(0, 15)) << 2;
         iss1_rd = 5'($urandom_range(0, 7)); iss1_wen = ($urandom_range(0, 3) != 0);
         iss2_sel = pick_sel(); iss2_pc = 64'($urandom_range(0, 15)) << 2;
         iss2_rd = 5'($urandom_range(0, 7)); iss2_wen = ($urandom_range(0, 3) != 0);
         done_vld = 3'($urandom);
         done_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         flush = ($urandom_range(0, 19) == 0);
         settle();
         n_checks++;
         if (wb0_en !== e_wb0_en || wb1_en !== e_wb1_en ||
             (e_wb0_en && (wb0_addr !== e_wb0_addr || wb0_data !== e_wb0_data)) ||
             (e_wb1_en && (wb1_addr !== e_wb1_addr || wb1_data !== e_wb1_data))) begin
            n_err++;
            $display("FAIL rand_wb c=%0d: got %b/%0d/%h %b/%0d/%h want %b/%0d/%h %b/%0d/%h", c,
                     wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
                     e_wb0_en, e_wb0_addr, e_wb0_data, e_wb1_en, e_wb1_addr, e_wb1_data);
         end
         clock();
         for (int u = 0; u < 3; u++) begin
            n_checks++;
            if (d_busy[u] !== m_busy(u) ||
                d_addr[u] !== (m_busy(u) ? m_rd[u] : 5'd0) ||
                d_ena[u]  !== (m_busy(u) && m_wen[u])) begin
               n_err++;
               $display("FAIL rand_status c=%0d u=%0d: got %b/%0d/%b want %b/%0d/%b", c, u,
                        d_busy[u], d_addr[u], d_ena[u], m_busy(u), m_busy(u) ? m_rd[u] : 5'd0,
                        m_busy(u) && m_wen[u]);
            end
         end
         n_checks++;
         if (wb_count !== m_count || err_issue_busy !== m_err) begin
            n_err++;
            $display("FAIL rand_count c=%0d: count=%0d err=%b want %0d %b", c, wb_count, err_issue_busy, m_count, m_err);
         end
      end
      rst = 0; idle_in();
   endtask

   initial begin
      idle_in();
      test_reset();
      test_single();
      test_order();
      test_same_rd();
      test_rd_zero();
      test_flush();
      test_back_to_back();
      test_busy_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
